// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

  // Arbiter sequencing state: idle, or one memory access in flight for F or M.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  // Word returned to the pipeline when an access is abandoned by the watchdog.
  localparam logic [31:0] ERR_WORD = 32'hDEADBEEF;

endpackage

// File: rtl/mem_arb_wdog.sv
// Watchdog counter for one memory access. Cleared by start, counts while
// run is high, and flags expiry on the TIMEOUT-th busy cycle.
module mem_arb_wdog #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic run,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  // Expiry is seen in the last allowed busy cycle so the arbiter leaves on that edge.
  assign expired = run && (count_reg == CW'(TIMEOUT - 1));

  // Next count: clear on start, otherwise advance while the access is outstanding.
  always_comb begin
    count_next = count_reg;
    if (start) begin
      count_next = '0;
    end else if (run && !expired) begin
      count_next = count_reg + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter sharing one unified memory between instruction
// fetch and load/store. Data accesses take priority over fetches; stall is
// held until every pending access of the current pipeline step is done.
// Optional watchdog: define MEM_ARB_TIMEOUT_EN to abandon an access after
// TIMEOUT busy cycles, returning ERR_WORD and setting the sticky memerr.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ireq,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] irdata,
  output logic          iready,
  input  logic          dreq,
  input  logic          dwe,
  input  logic [AW-1:0] daddr,
  input  logic [DW-1:0] dwdata,
  output logic [DW-1:0] drdata,
  output logic          dready,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          stall,
  output logic          memerr
);

  // A zero limit would expire before the first request cycle.
  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT must be at least 1");
  end

  arb_state_t    state_reg, state_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic          we_reg, we_next;
  logic [DW-1:0] wdata_reg, wdata_next;
  logic          i_done_reg, i_done_next;
  logic          d_done_reg, d_done_next;
  logic [DW-1:0] irdata_reg, irdata_next;
  logic [DW-1:0] drdata_reg, drdata_next;
  logic          i_set, d_set;
  logic          pend_i, pend_d;
  logic          busy;
  logic          expired;
  logic          timeout_hit;

  assign pend_i = ireq && !i_done_reg;
  assign pend_d = dreq && !d_done_reg;
  assign stall  = pend_i || pend_d;
  assign busy   = (state_reg == BUSY_I) || (state_reg == BUSY_D);

  // An acknowledge in the same cycle always beats the watchdog.
  assign timeout_hit = busy && !mem_ack && expired;

`ifdef MEM_ARB_TIMEOUT_EN
  logic memerr_reg;

  // Counter is held clear while idle, so every access starts from zero.
  mem_arb_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .start   (!busy),
    .run     (busy),
    .expired (expired)
  );

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      memerr_reg <= 1'b0;
    end else if (timeout_hit) begin
      memerr_reg <= 1'b1;
    end
  end

  assign memerr = memerr_reg;
`else
  assign expired = 1'b0;
  assign memerr  = 1'b0;
`endif

  // Memory port is driven only while an access is in flight; zero otherwise.
  assign mem_req   = busy;
  assign mem_we    = busy && we_reg;
  assign mem_addr  = busy ? addr_reg : '0;
  assign mem_wdata = busy ? wdata_reg : '0;

  assign iready = i_done_reg;
  assign dready = d_done_reg;
  assign irdata = irdata_reg;
  assign drdata = drdata_reg;

  // Next-state, request latching, read-data capture and done-flag update.
  always_comb begin
    state_next  = state_reg;
    addr_next   = addr_reg;
    we_next     = we_reg;
    wdata_next  = wdata_reg;
    irdata_next = irdata_reg;
    drdata_next = drdata_reg;
    i_set       = 1'b0;
    d_set       = 1'b0;

    case (state_reg)
      IDLE: begin
        // The load/store belongs to the older instruction, so it goes first.
        if (pend_d) begin
          state_next = BUSY_D;
          addr_next  = daddr;
          we_next    = dwe;
          wdata_next = dwdata;
        end else if (pend_i) begin
          state_next = BUSY_I;
          addr_next  = iaddr;
          we_next    = 1'b0;
          wdata_next = '0;
        end
      end
      BUSY_I: begin
        if (mem_ack) begin
          irdata_next = mem_rdata;
          i_set       = 1'b1;
          state_next  = IDLE;
        end else if (timeout_hit) begin
          irdata_next = DW'(ERR_WORD);
          i_set       = 1'b1;
          state_next  = IDLE;
        end
      end
      BUSY_D: begin
        if (mem_ack) begin
          drdata_next = mem_rdata;
          d_set       = 1'b1;
          state_next  = IDLE;
        end else if (timeout_hit) begin
          drdata_next = DW'(ERR_WORD);
          d_set       = 1'b1;
          state_next  = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // The pipeline advances on any edge without stall, so the flags reset then.
    i_done_next = stall ? (i_done_reg || i_set) : 1'b0;
    d_done_next = stall ? (d_done_reg || d_set) : 1'b0;
  end

  // State, latched request fields, flags and read-data registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      we_reg     <= 1'b0;
      wdata_reg  <= '0;
      i_done_reg <= 1'b0;
      d_done_reg <= 1'b0;
      irdata_reg <= '0;
      drdata_reg <= '0;
    end else begin
      state_reg  <= state_next;
      addr_reg   <= addr_next;
      we_reg     <= we_next;
      wdata_reg  <= wdata_next;
      i_done_reg <= i_done_next;
      d_done_reg <= d_done_next;
      irdata_reg <= irdata_next;
      drdata_reg <= drdata_next;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table for fetch, data
// priority and back-to-back loads, plus hand sequences for a delayed store,
// reset mid-access and (with MEM_ARB_TIMEOUT_EN) the watchdog.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq, dreq, dwe, mem_ack;
  logic [31:0] iaddr, daddr, dwdata, mem_rdata;
  logic [31:0] irdata, drdata, mem_addr, mem_wdata;
  logic        iready, dready, mem_req, mem_we, stall, memerr;

  int checks   = 0;
  int failures = 0;

  mem_arbiter #(
    .AW      (32),
    .DW      (32),
    .TIMEOUT (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ireq      (ireq),
    .iaddr     (iaddr),
    .irdata    (irdata),
    .iready    (iready),
    .dreq      (dreq),
    .dwe       (dwe),
    .daddr     (daddr),
    .dwdata    (dwdata),
    .drdata    (drdata),
    .dready    (dready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .stall     (stall),
    .memerr    (memerr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_iready;
    logic [31:0] e_irdata;
    logic        e_dready;
    logic [31:0] e_drdata;
    logic        e_stall;
  } vec_t;

  function automatic vec_t v(
    input logic ir, input logic [31:0] ia, input logic dr, input logic we,
    input logic [31:0] da, input logic [31:0] dw, input logic ak, input logic [31:0] rd,
    input logic xq, input logic xw, input logic [31:0] xa, input logic [31:0] xd,
    input logic xir, input logic [31:0] xid, input logic xdr, input logic [31:0] xdd,
    input logic xs);
    vec_t r;
    r.ireq = ir; r.iaddr = ia; r.dreq = dr; r.dwe = we; r.daddr = da; r.dwdata = dw;
    r.ack = ak; r.rdata = rd; r.e_req = xq; r.e_we = xw; r.e_addr = xa; r.e_wdata = xd;
    r.e_iready = xir; r.e_irdata = xid; r.e_dready = xdr; r.e_drdata = xdd; r.e_stall = xs;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic we,
                       input logic [31:0] da, input logic [31:0] dw, input logic ak,
                       input logic [31:0] rd);
    ireq = ir; iaddr = ia; dreq = dr; dwe = we; daddr = da; dwdata = dw;
    mem_ack = ak; mem_rdata = rd;
  endtask

  // Advance to the next cycle: drive point is 1 ns after the rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[17];

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n_req;

    //       ireq iaddr dreq we daddr dwdata ack rdata | req we addr wdata ir irdata dr drdata stall
    vecs[0]  = v(0, 32'h0,  0, 0, 32'h0,   0, 0, 32'h0,        0, 0, 32'h0,   0, 0, 32'h0,        0, 32'h0,        0);
    vecs[1]  = v(1, 32'h40, 0, 0, 32'h0,   0, 0, 32'h0,        0, 0, 32'h0,   0, 0, 32'h0,        0, 32'h0,        1);
    vecs[2]  = v(1, 32'h40, 0, 0, 32'h0,   0, 1, 32'h20080005, 1, 0, 32'h40,  0, 0, 32'h0,        0, 32'h0,        1);
    vecs[3]  = v(1, 32'h40, 0, 0, 32'h0,   0, 0, 32'h0,        0, 0, 32'h0,   0, 1, 32'h20080005, 0, 32'h0,        0);
    vecs[4]  = v(1, 32'h44, 1, 0, 32'h100, 0, 0, 32'h0,        0, 0, 32'h0,   0, 0, 32'h20080005, 0, 32'h0,        1);
    vecs[5]  = v(1, 32'h44, 1, 0, 32'h100, 0, 1, 32'h11111111, 1, 0, 32'h100, 0, 0, 32'h20080005, 0, 32'h0,        1);
    vecs[6]  = v(1, 32'h44, 1, 0, 32'h100, 0, 0, 32'h0,        0, 0, 32'h0,   0, 0, 32'h20080005, 1, 32'h11111111, 1);
    vecs[7]  = v(1, 32'h44, 1, 0, 32'h100, 0, 1, 32'h22222222, 1, 0, 32'h44,  0, 0, 32'h20080005, 1, 32'h11111111, 1);
    vecs[8]  = v(1, 32'h44, 1, 0, 32'h100, 0, 0, 32'h0,        0, 0, 32'h0,   0, 1, 32'h22222222, 1, 32'h11111111, 0);
    vecs[9]  = v(0, 32'h0,  1, 0, 32'h200, 0, 0, 32'h0,        0, 0, 32'h0,   0, 0, 32'h22222222, 0, 32'h11111111, 1);
    vecs[10] = v(0, 32'h0,  1, 0, 32'h200, 0, 1, 32'h33,       1, 0, 32'h200, 0, 0, 32'h22222222, 0, 32'h11111111, 1);
    vecs[11] = v(0, 32'h0,  1, 0, 32'h200, 0, 0, 32'h0,        0, 0, 32'h0,   0, 0, 32'h22222222, 1, 32'h33,       0);
    vecs[12] = v(0, 32'h0,  1, 0, 32'h204, 0, 0, 32'h0,        0, 0, 32'h0,   0, 0, 32'h22222222, 0, 32'h33,       1);
    vecs[13] = v(0, 32'h0,  1, 0, 32'h204, 0, 1, 32'h44,       1, 0, 32'h204, 0, 0, 32'h22222222, 0, 32'h33,       1);
    vecs[14] = v(0, 32'h0,  1, 0, 32'h204, 0, 0, 32'h0,        0, 0, 32'h0,   0, 0, 32'h22222222, 1, 32'h44,       0);
    vecs[15] = v(0, 32'h0,  0, 0, 32'h0,   0, 1, 32'h55,       0, 0, 32'h0,   0, 0, 32'h22222222, 0, 32'h44,       0);
    vecs[16] = v(0, 32'h0,  0, 0, 32'h0,   0, 0, 32'h0,        0, 0, 32'h0,   0, 0, 32'h22222222, 0, 32'h44,       0);

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Table: one row per cycle; inputs at posedge+1, outputs checked at negedge.
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].ireq, vecs[i].iaddr, vecs[i].dreq, vecs[i].dwe,
            vecs[i].daddr, vecs[i].dwdata, vecs[i].ack, vecs[i].rdata);
      @(negedge clk);
      chk($sformatf("v%0d mem_req", i),   32'(mem_req),   32'(vecs[i].e_req));
      chk($sformatf("v%0d mem_we", i),    32'(mem_we),    32'(vecs[i].e_we));
      chk($sformatf("v%0d mem_addr", i),  mem_addr,       vecs[i].e_addr);
      chk($sformatf("v%0d mem_wdata", i), mem_wdata,      vecs[i].e_wdata);
      chk($sformatf("v%0d iready", i),    32'(iready),    32'(vecs[i].e_iready));
      chk($sformatf("v%0d irdata", i),    irdata,         vecs[i].e_irdata);
      chk($sformatf("v%0d dready", i),    32'(dready),    32'(vecs[i].e_dready));
      chk($sformatf("v%0d drdata", i),    drdata,         vecs[i].e_drdata);
      chk($sformatf("v%0d stall", i),     32'(stall),     32'(vecs[i].e_stall));
      chk($sformatf("v%0d memerr", i),    32'(memerr),    32'h0);
      $display("vec %0d: ireq=%0b dreq=%0b ack=%0b -> req=%0b addr=%h stall=%0b",
               i, ireq, dreq, mem_ack, mem_req, mem_addr, stall);
      next_cycle();
    end

    // Store with ack delayed 3 cycles: memory port held for 4 cycles.
    drive(0, 0, 1, 1, 32'h80, 32'hCAFE, 0, 0);
    @(negedge clk);
    chk("st c0 stall", 32'(stall), 32'h1);
    chk("st c0 mem_req", 32'(mem_req), 32'h0);
    n_req = 0;
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      mem_ack = (c == 4);
      @(negedge clk);
      n_req += int'(mem_req);
      chk($sformatf("st c%0d mem_req", c),   32'(mem_req), 32'h1);
      chk($sformatf("st c%0d mem_we", c),    32'(mem_we), 32'h1);
      chk($sformatf("st c%0d mem_addr", c),  mem_addr, 32'h80);
      chk($sformatf("st c%0d mem_wdata", c), mem_wdata, 32'hCAFE);
      chk($sformatf("st c%0d dready", c),    32'(dready), 32'h0);
    end
    next_cycle();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("st c5 dready", 32'(dready), 32'h1);
    chk("st c5 stall", 32'(stall), 32'h0);
    chk("st c5 mem_req", 32'(mem_req), 32'h0);
    chk("st req_cycles", 32'(n_req), 32'd4);
    $display("store: addr=80 data=CAFE req_cycles=%0d dready=%0b", n_req, dready);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();

    // Reset while in BUSY_D, then a stray late ack.
    drive(0, 0, 1, 0, 32'h300, 0, 0, 0);
    next_cycle();
    @(negedge clk);
    chk("rst busy mem_req", 32'(mem_req), 32'h1);
    chk("rst busy mem_addr", mem_addr, 32'h300);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1, 32'h77);
    @(negedge clk);
    chk("rst after mem_req", 32'(mem_req), 32'h0);
    chk("rst after dready", 32'(dready), 32'h0);
    chk("rst after iready", 32'(iready), 32'h0);
    chk("rst after drdata", drdata, 32'h0);
    chk("rst after irdata", irdata, 32'h0);
    chk("rst after stall", 32'(stall), 32'h0);
    next_cycle();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("rst stray dready", 32'(dready), 32'h0);
    chk("rst stray drdata", drdata, 32'h0);
    chk("rst stray mem_req", 32'(mem_req), 32'h0);
    $display("reset mid-access: mem_req=%0b dready=%0b drdata=%h", mem_req, dready, drdata);
    next_cycle();

`ifdef MEM_ARB_TIMEOUT_EN
    // Watchdog: no ack, TIMEOUT=4 -> four request cycles then error completion.
    drive(0, 0, 1, 0, 32'h500, 0, 0, 0);
    n_req = 0;
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      @(negedge clk);
      n_req += int'(mem_req);
      chk($sformatf("to c%0d mem_req", c), 32'(mem_req), 32'h1);
    end
    next_cycle();
    @(negedge clk);
    chk("to mem_req", 32'(mem_req), 32'h0);
    chk("to dready", 32'(dready), 32'h1);
    chk("to drdata", drdata, 32'hDEADBEEF);
    chk("to memerr", 32'(memerr), 32'h1);
    chk("to stall", 32'(stall), 32'h0);
    $display("timeout: req_cycles=%0d drdata=%h memerr=%0b", n_req, drdata, memerr);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) next_cycle();
    @(negedge clk);
    chk("to memerr sticky", 32'(memerr), 32'h1);
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("to memerr reset", 32'(memerr), 32'h0);
    next_cycle();
`else
    // Without the watchdog the arbiter keeps waiting and memerr stays low.
    drive(0, 0, 1, 0, 32'h500, 0, 0, 0);
    repeat (8) next_cycle();
    @(negedge clk);
    chk("nowd mem_req", 32'(mem_req), 32'h1);
    chk("nowd dready", 32'(dready), 32'h0);
    chk("nowd memerr", 32'(memerr), 32'h0);
    $display("no watchdog: mem_req=%0b memerr=%0b after 8 cycles", mem_req, memerr);
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
